control_unit: RTL

Multi-cycle controller that drives the 8-bit datapath ALU. It fetches 16-bit instructions over a request/valid handshake and decodes them into `aluControl`, register-file addresses, an immediate select and a write strobe. It closes the branch loop by sampling the ALU `equality` flag. It owns the 8-bit program counter and sits between instruction memory and the register-file/ALU datapath.

---
 rtl/control_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit ALU datapath.
// Owns the program counter, instruction register and retired-instruction counter.
module control_unit #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instrReq,
  output logic [7:0]  pc,
  input  logic        instrValid,
  input  logic [15:0] instr,
  output logic [2:0]  aluControl,
  output logic        aluSrcImm,
  output logic [1:0]  rdAddr,
  output logic [1:0]  rsAddr,
  output logic [7:0]  imm,
  input  logic        equality,
  output logic        regWrite,
  output logic        halted,
  output logic [7:0]  retiredCount
);

  localparam int unsigned PC_W  = 8;
  localparam int unsigned IR_W  = 16;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'b111;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [IR_W-1:0]   ir;
  logic [PC_W-1:0]   pc_q;
  logic [CNT_W-1:0]  retired_q;
  logic [OP_W-1:0]   op;
  logic              is_branch_op;
  logic              is_halt;
  logic              fetch_accept;
  logic              exec_retire;

  assign op           = ir[15:13];
  assign is_branch_op = (op == OP_BRANCH);
  assign is_halt      = is_branch_op && ir[12];
  assign fetch_accept = (state == S_FETCH) && instrValid;
  assign exec_retire  = (state == S_EXECUTE);

  // Field decode straight from the instruction register.
  assign pc           = pc_q;
  assign retiredCount = retired_q;
  assign rdAddr       = ir[11:10];
  assign rsAddr       = ir[9:8];
  assign imm          = ir[7:0];
  assign aluSrcImm    = ir[12] && !is_branch_op;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // Instruction capture, program counter and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir        <= '0;
      pc_q      <= PC_RESET;
      retired_q <= '0;
    end else begin
      if (fetch_accept) begin
        ir   <= instr;
        pc_q <= pc_q + PC_W'(1);
      end
      if (exec_retire) begin
        retired_q <= retired_q + CNT_W'(1);
        if (is_branch_op && equality) begin
          pc_q <= ir[7:0];
        end
      end
    end
  end

  // Next-state and control strobes; reset gates the fetch request and write strobe.
  always_comb begin
    state_nx   = state;
    instrReq   = 1'b0;
    aluControl = '0;
    regWrite   = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        instrReq = !reset;
        if (instrValid) begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        aluControl = op;
        state_nx   = is_halt ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        aluControl = op;
        regWrite   = !reset && !is_branch_op;
        state_nx   = S_FETCH;
      end
      S_HALT: begin
        aluControl = op;
        halted     = 1'b1;
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase
  end

endmodule
